// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the shared-arithmetic-unit controllers:
// fp16 field widths, controller state encoding and round-robin helpers.
package fp_ctrl_pkg;

    localparam int EXP_WIDTH       = 5;
    localparam int MANT_WIDTH      = 10;
    localparam int DATA_WIDTH      = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int DEFAULT_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_e;

    // Index of the requester following idx in a ring of n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request starting
// at ptr and wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int unsigned pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!any && req[pos[IDX_W-1:0]]) begin
                any                 = 1'b1;
                gnt[pos[IDX_W-1:0]] = 1'b1;
                idx                 = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one external combinational fp16 adder between NUM_REQ requesters:
// round-robin grant, one operation in flight, registered operands and result.
module fp_add_arbiter
    import fp_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH = fp_ctrl_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [DATA_WIDTH-1:0]         add_a,
    output logic [DATA_WIDTH-1:0]         add_b,
    input  logic [DATA_WIDTH-1:0]         add_result,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          op_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    ctrl_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0]      tag_q, tag_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;
    logic                  rsp_hs;
    logic                  grant_en;

    logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[g] = req_b[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        result_d   = result_q;
        tag_d      = tag_q;
        rr_ptr_d   = rr_ptr_q;
        op_count_d = op_count_q;

        rsp_hs    = (state_q == RESP) && rsp_ready[tag_q];
        // rst_n gating keeps req_ready low for the whole reset interval.
        grant_en  = rst_n && arb_any && ((state_q == IDLE) || rsp_hs);
        req_ready = grant_en ? arb_gnt : '0;
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[tag_q] = 1'b1;
        end

        case (state_q)
            IDLE: ;
            EXEC: begin
                result_d = add_result;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    op_count_d = op_count_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A grant in RESP overrides the return to IDLE for back-to-back issue.
        if (grant_en) begin
            op_a_d   = a_arr[arb_idx];
            op_b_d   = b_arr[arb_idx];
            tag_d    = arb_idx;
            rr_ptr_d = IDX_W'(rr_next(32'(arb_idx), NUM_REQ));
            state_d  = EXEC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            result_q   <= '0;
            tag_q      <= '0;
            rr_ptr_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            result_q   <= result_d;
            tag_q      <= tag_d;
            rr_ptr_q   <= rr_ptr_d;
            op_count_q <= op_count_d;
        end
    end

    assign add_a    = op_a_q;
    assign add_b    = op_b_q;
    assign rsp_data = result_q;
    assign busy     = (state_q != IDLE);
    assign op_count = op_count_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter with a behavioural fp16 adder
// (positive normal operands, truncating) on the add_* ports.
module tb_fp_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready = '0;
    logic [15:0] rsp_data, add_a, add_b, add_result;
    logic        busy;
    logic [15:0] op_count;

    logic [1:0]  w_req_valid = '0;
    logic [1:0]  w_req_ready;
    logic [31:0] w_req_a = {16'h3C00, 16'h3C00};
    logic [31:0] w_req_b = {16'h4000, 16'h3C00};
    logic [1:0]  w_rsp_valid;
    logic [1:0]  w_rsp_ready = '0;
    logic [15:0] w_rsp_data, w_add_a, w_add_b, w_add_result;
    logic        w_busy;
    logic [3:0]  w_op_count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] fp_add(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] hi, lo;
        logic [4:0]  e;
        logic [11:0] mh, ml, s;
        if (y[14:10] > x[14:10]) begin hi = y; lo = x; end
        else begin hi = x; lo = y; end
        e  = hi[14:10];
        mh = {2'b01, hi[9:0]};
        ml = {2'b01, lo[9:0]} >> (hi[14:10] - lo[14:10]);
        s  = mh + ml;
        if (s[11]) begin
            s = s >> 1;
            e = e + 5'd1;
        end
        return {1'b0, e, s[9:0]};
    endfunction

    assign add_result   = fp_add(add_a, add_b);
    assign w_add_result = fp_add(w_add_a, w_add_b);

    fp_add_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .busy(busy), .op_count(op_count)
    );

    fp_add_arbiter #(.NUM_REQ(2), .DATA_WIDTH(16), .CNT_WIDTH(4)) u_dut_w (
        .clk(clk), .rst_n(rst_n),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_a(w_req_a), .req_b(w_req_b),
        .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_data(w_rsp_data),
        .add_a(w_add_a), .add_b(w_add_b), .add_result(w_add_result),
        .busy(w_busy), .op_count(w_op_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          tag;
        logic [15:0] data;
        int          cyc;
    } sb_t;

    sb_t         sb[$];
    sb_t         e;
    int          grant_log[$];
    int          grant_cyc[$];
    int          grant_cnt[4] = '{0, 0, 0, 0};
    int          cyc = 0;
    int          w_cnt = 0;
    logic [15:0] exp_cnt = '0;
    logic [15:0] r2_data = '0;
    logic        prev_rsp = 1'b0;
    logic        hs;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_cnt  = '0;
            prev_rsp = 1'b0;
            w_cnt    = 0;
        end else begin
            cyc++;
            hs = 1'b0;
            check("op_count", 32'(op_count), 32'(exp_cnt));
            check("w_op_count", 32'(w_op_count), 32'(w_cnt % 16));
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_spurious", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb[0];
                    if (!prev_rsp) check("rsp_latency", cyc - e.cyc, 32'd2);
                    check("rsp_valid", 32'(rsp_valid), 32'd1 << e.tag);
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    if (rsp_ready[e.tag]) begin
                        hs = 1'b1;
                        void'(sb.pop_front());
                        exp_cnt++;
                        if (e.tag == 2) r2_data = rsp_data;
                    end
                end
            end else if (sb.size() != 0 && cyc > sb[0].cyc + 2) begin
                check("rsp_missing", 32'(rsp_valid), 32'd1 << sb[0].tag);
            end
            prev_rsp = (rsp_valid != '0) && !hs;
            if (req_ready != '0) begin
                check("grant_onehot", $countones(req_ready), 32'd1);
                check("grant_valid", 32'(req_ready & ~req_valid), 32'd0);
                for (int i = 0; i < 4; i++) begin
                    if (req_ready[i]) begin
                        sb.push_back('{i, fp_add(req_a[i*16 +: 16], req_b[i*16 +: 16]), cyc});
                        grant_cnt[i]++;
                        grant_log.push_back(i);
                        grant_cyc.push_back(cyc);
                    end
                end
            end
            if ((w_rsp_valid & w_rsp_ready) != '0) w_cnt++;
        end
    end

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    task automatic wait_grant(input int i);
        logic seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = req_ready[i];
        end
        if (!seen) check("wait_grant", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        logic seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = !busy && (rsp_valid == '0);
        end
        if (!seen) check("wait_idle", 32'd0, 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_op_count"}, 32'(op_count), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_add_a"}, 32'(add_a), 32'd0);
        check({tag, "_add_b"}, 32'(add_b), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g2;
        req_valid = 4'b1111;
        #3;
        check_zero_outputs("reset");
        #20;
        req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;

        // single request
        set_ops(0, 16'h3C00, 16'h3C00);
        @(posedge clk); #1;
        rsp_ready = 4'b1111;
        req_valid = 4'b0001;
        wait_grant(0);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("single_exec_busy", 32'(busy), 32'd1);
        check("single_exec_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("single_rsp_valid", 32'(rsp_valid), 32'b0001);
        check("single_rsp_data", 32'(rsp_data), 32'h4000);
        @(negedge clk);
        check("single_count", 32'(op_count), 32'd1);
        check("single_idle", 32'(busy), 32'd0);

        // backpressure on requester 1 while requester 3 waits
        set_ops(1, 16'h3C00, 16'h3800);
        set_ops(3, 16'h4000, 16'h4000);
        @(posedge clk); #1;
        rsp_ready = 4'b1101;
        req_valid = 4'b0010;
        wait_grant(1);
        @(posedge clk); #1 req_valid = 4'b1000;
        @(negedge clk);
        check("bp_exec_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'b0010);
            check("bp_hold_data", 32'(rsp_data), 32'h3E00);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 4'b1111;
        @(negedge clk);
        check("bp_release_grant", 32'(req_ready), 32'b1000);
        check("bp_release_valid", 32'(rsp_valid), 32'b0010);
        @(posedge clk); #1 req_valid = '0;
        wait_idle();

        // withdrawal of requester 2 during EXEC
        g2 = grant_cnt[2];
        set_ops(2, 16'h3C00, 16'h4000);
        @(posedge clk); #1 req_valid = 4'b0001;
        wait_grant(0);
        @(posedge clk); #1 req_valid = 4'b0100;
        @(negedge clk);
        check("wd_exec_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1 req_valid = '0;
        wait_idle();
        #1;
        check("wd_never_granted", grant_cnt[2], g2);
        check("wd_sb_empty", sb.size(), 32'd0);

        // reset during EXEC
        @(posedge clk); #1 req_valid = 4'b0010;
        wait_grant(1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check_zero_outputs("rst_exec");
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);

        // fairness with all requesters valid
        #1;
        grant_log.delete();
        grant_cyc.delete();
        set_ops(0, 16'h3C00, 16'h3C00);
        set_ops(1, 16'h3C00, 16'h3800);
        set_ops(2, 16'h3C00, 16'h4000);
        set_ops(3, 16'h3C00, 16'h4400);
        @(posedge clk); #1 req_valid = 4'b1111;
        repeat (10) @(posedge clk);
        #1 req_valid = '0;
        wait_idle();
        #1;
        check("rr_grants", grant_log.size(), 32'd5);
        if (grant_log.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                check("rr_order", grant_log[k], k % 4);
                if (k > 0) check("rr_spacing", grant_cyc[k] - grant_cyc[k-1], 32'd2);
            end
        end
        check("rr_req2_sum", 32'(r2_data), 32'h4200);

        // counter wrap on the 4-bit counter instance
        @(posedge clk); #1;
        w_rsp_ready = 2'b11;
        w_req_valid = 2'b11;
        for (int k = 0; k < 80 && w_cnt < 17; k++) @(negedge clk);
        #1 w_req_valid = '0;
        repeat (4) @(negedge clk);
        #1;
        check("wrap_reached", 32'(w_cnt >= 17), 32'd1);
        check("wrap_count", 32'(w_op_count), 32'(w_cnt % 16));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
